// File: rtl/ptw_mem_responder.sv
// ptw_mem_responder: answers the page-table walker's data-cache request port
// from an SRAM-style backing store, one outstanding 64-bit read at a time.
// Optional build macro: PTW_RESP_RANGE_CHK_EN -- reject loads whose physical
// address falls outside [BASE_ADDR, BASE_ADDR + MEM_SIZE) without touching memory.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | granting data_req combinationally, latching index/we
// TAG      | waiting for tag_valid (or kill) to form the physical address
// MEM_REQ  | mem_req_o held high until the backing store grants
// MEM_WAIT | waiting for mem_rvalid_i, then capturing the read word
// RESP     | data_rvalid high for one cycle; no grant in this cycle

package ptw_mem_responder_pkg;
  localparam int unsigned PLEN  = 34;
  localparam int unsigned IDX_W = 12;
  localparam int unsigned TAG_W = PLEN - IDX_W;

  typedef struct packed {
    logic [31:0] xlen;
    logic [31:0] plen;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  typedef struct packed {
    logic [IDX_W-1:0] address_index;
    logic [TAG_W-1:0] address_tag;
    logic [63:0]      data_wdata;
    logic             data_req;
    logic             data_we;
    logic [7:0]       data_be;
    logic [1:0]       data_size;
    logic             kill_req;
    logic             tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [3:0]  data_rid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;
endpackage

module ptw_mem_responder
  import ptw_mem_responder_pkg::*;
#(
  parameter cva6_cfg_t         CVA6Cfg   = cva6_cfg_empty,
  parameter logic [PLEN-1:0]   BASE_ADDR = PLEN'('h8000_0000),
  parameter logic [PLEN:0]     MEM_SIZE  = (PLEN+1)'('h1_0000)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  dcache_req_i_t       req_port_i,
  output dcache_req_o_t       req_port_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic [PLEN-1:0]     mem_addr_o,
  input  logic                mem_rvalid_i,
  input  logic [63:0]         mem_rdata_i,
  output logic                err_o
);

  typedef enum logic [2:0] {IDLE, TAG, MEM_REQ, MEM_WAIT, RESP} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             we_q;
  logic [63:0]      rdata_q;
  logic             rvalid_q;
  logic             mem_req_q;
  logic [PLEN-1:0]  mem_addr_q;
  logic             err_q;

  logic [PLEN-1:0]  paddr;
  logic             in_range;
  logic             wr_err;

  // The tag arrives a cycle after the index, so it is taken live from the port.
  assign paddr = {req_port_i.address_tag, idx_q};

  // Fields of the request port this responder has no use for.
  logic unused_req;
  assign unused_req = ^{req_port_i.data_wdata, req_port_i.data_be, req_port_i.data_size};

`ifdef PTW_RESP_RANGE_CHK_EN
  // Extra headroom bit so BASE_ADDR + MEM_SIZE cannot wrap near the top of memory.
  assign in_range = ({2'b0, paddr} >= {2'b0, BASE_ADDR}) &&
                    ({2'b0, paddr} <  ({2'b0, BASE_ADDR} + {1'b0, MEM_SIZE}));
  logic unused_cfg;
  assign unused_cfg = ^{CVA6Cfg};
`else
  assign in_range = 1'b1;
  logic unused_cfg;
  assign unused_cfg = ^{CVA6Cfg, BASE_ADDR, MEM_SIZE};
`endif

  // A dropped write is reported in the very cycle its tag shows up.
  assign wr_err = (state_q == TAG) && req_port_i.tag_valid &&
                  !req_port_i.kill_req && we_q;
  assign err_o      = err_q | wr_err;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

  // Response port: grant only while idle, everything else comes from registers.
  always_comb begin
    req_port_o             = '0;
    req_port_o.data_gnt    = (state_q == IDLE) && req_port_i.data_req;
    req_port_o.data_rvalid = rvalid_q;
    req_port_o.data_rdata  = rdata_q;
  end

  // Request sequencing FSM with registered responses and memory handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_port_i.data_req) begin
            idx_q   <= req_port_i.address_index;
            we_q    <= req_port_i.data_we;
            state_q <= TAG;
          end
        end
        TAG: begin
          // Kill wins whether or not the tag is valid in the same cycle.
          if (req_port_i.kill_req) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b1;
            state_q  <= RESP;
          end else if (req_port_i.tag_valid) begin
            if (we_q) begin
              state_q <= IDLE;
            end else if (!in_range) begin
              rdata_q  <= '0;
              rvalid_q <= 1'b1;
              err_q    <= 1'b1;
              state_q  <= RESP;
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= {paddr[PLEN-1:3], 3'b000};
              state_q    <= MEM_REQ;
            end
          end
        end
        MEM_REQ: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_rvalid_i) begin
            rdata_q  <= mem_rdata_i;
            rvalid_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Bench for ptw_mem_responder: scenario tasks with a queue of expected read data.
module tb_ptw_mem_responder;
  import ptw_mem_responder_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b1;
  dcache_req_i_t   req_i;
  dcache_req_o_t   rsp_o;
  logic            mem_req;
  logic            mem_gnt;
  logic [PLEN-1:0] mem_addr;
  logic            mem_rvalid;
  logic [63:0]     mem_rdata;
  logic            err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  ptw_mem_responder dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_port_i   (req_i),
    .req_port_o   (rsp_o),
    .mem_req_o    (mem_req),
    .mem_gnt_i    (mem_gnt),
    .mem_addr_o   (mem_addr),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .err_o        (err)
  );

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200us");
    $fatal(1, "timeout");
  end

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic drive_idle();
    req_i      = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h5A5A_5A5A_A5A5_A5A5;
  endtask

  task automatic test_reset();
    drive_idle();
    #2 rst_ni = 1'b0;
    #2;
    checks++; if (rsp_o !== '0) begin errors++; $display("FAIL reset_rsp: got %h want 0", rsp_o); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    next_cyc();
    rst_ni = 1'b1;
    next_cyc();
    checks++; if (rsp_o.data_gnt !== 1'b0) begin errors++; $display("FAIL idle_gnt: got %b want 0", rsp_o.data_gnt); end
    checks++; if (rsp_o.data_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid: got %b want 0", rsp_o.data_rvalid); end
  endtask

  // Full load; gw/rw add grant-wait and memory-latency cycles. hold2 keeps a
  // second request asserted throughout, which is then killed after its grant.
  task automatic do_load(input logic [PLEN-1:0] paddr, input logic [63:0] data,
                         input int gw, input int rw, input bit hold2, input string nm);
    int c0;
    bit got;
    logic [63:0] e;
    logic [PLEN-1:0] aligned;
    aligned = {paddr[PLEN-1:3], 3'b000};
    req_i.data_req      = 1'b1;
    req_i.data_we       = 1'b0;
    req_i.address_index = paddr[IDX_W-1:0];
    #1;
    checks++; if (rsp_o.data_gnt !== 1'b1) begin errors++; $display("FAIL %s gnt_c0: got %b want 1", nm, rsp_o.data_gnt); end
    c0 = cyc;
    next_cyc();
    req_i.data_req      = hold2;
    req_i.address_index = 12'h0F8;
    req_i.tag_valid     = 1'b1;
    req_i.address_tag   = paddr[PLEN-1:IDX_W];
    exp_q.push_back(data);
    #1;
    checks++; if (rsp_o.data_gnt !== 1'b0) begin errors++; $display("FAIL %s gnt_c1: got %b want 0", nm, rsp_o.data_gnt); end
    next_cyc();
    req_i.tag_valid   = 1'b0;
    req_i.address_tag = '1;
    mem_gnt = (gw == 0);
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL %s mem_req_c2: got %b want 1", nm, mem_req); end
    checks++; if (mem_addr !== aligned) begin errors++; $display("FAIL %s mem_addr: got %h want %h", nm, mem_addr, aligned); end
    for (int i = 0; i < gw; i++) begin
      next_cyc();
      mem_gnt = (i == gw - 1);
      #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL %s mem_req_wait: got %b want 1", nm, mem_req); end
      if (hold2) begin
        checks++; if (rsp_o.data_gnt !== 1'b0) begin errors++; $display("FAIL %s gnt_busy: got %b want 0", nm, rsp_o.data_gnt); end
      end
    end
    next_cyc();
    mem_gnt = 1'b0;
    for (int i = 0; i < rw; i++) begin
      mem_rvalid = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL %s mem_req_after_gnt: got %b want 0", nm, mem_req); end
      if (hold2) begin
        checks++; if (rsp_o.data_gnt !== 1'b0) begin errors++; $display("FAIL %s gnt_busy: got %b want 0", nm, rsp_o.data_gnt); end
      end
      next_cyc();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    next_cyc();
    mem_rvalid = 1'b0;
    mem_rdata  = ~data;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      #1;
      if (rsp_o.data_rvalid === 1'b1) got = 1'b1;
      else next_cyc();
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s rvalid_timeout: got no rvalid want rvalid at c%0d", nm, 4 + gw + rw);
    end else begin
      e = exp_q.pop_front();
      checks++; if (cyc - c0 !== 4 + gw + rw) begin errors++; $display("FAIL %s latency: got c%0d want c%0d", nm, cyc - c0, 4 + gw + rw); end
      checks++; if (rsp_o.data_rdata !== e) begin errors++; $display("FAIL %s rdata: got %h want %h", nm, rsp_o.data_rdata, e); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err: got %b want 0", nm, err); end
      checks++; if (rsp_o.data_gnt !== 1'b0) begin errors++; $display("FAIL %s gnt_resp: got %b want 0", nm, rsp_o.data_gnt); end
      next_cyc();
      checks++; if (rsp_o.data_rvalid !== 1'b0) begin errors++; $display("FAIL %s rvalid_width: got %b want 0", nm, rsp_o.data_rvalid); end
      checks++; if (rsp_o.data_rdata !== e) begin errors++; $display("FAIL %s rdata_hold: got %h want %h", nm, rsp_o.data_rdata, e); end
      if (hold2) begin
        checks++; if (rsp_o.data_gnt !== 1'b1) begin errors++; $display("FAIL %s gnt_second: got %b want 1", nm, rsp_o.data_gnt); end
        next_cyc();
        req_i.data_req  = 1'b0;
        req_i.tag_valid = 1'b1;
        req_i.kill_req  = 1'b1;
        exp_q.push_back(64'h0);
        next_cyc();
        req_i.tag_valid = 1'b0;
        req_i.kill_req  = 1'b0;
        e = exp_q.pop_front();
        checks++; if (rsp_o.data_rvalid !== 1'b1) begin errors++; $display("FAIL %s second_rvalid: got %b want 1", nm, rsp_o.data_rvalid); end
        checks++; if (rsp_o.data_rdata !== e) begin errors++; $display("FAIL %s second_rdata: got %h want %h", nm, rsp_o.data_rdata, e); end
      end
    end
    drive_idle();
    next_cyc();
  endtask

  task automatic test_kill(input bit with_tag, input string nm);
    logic [63:0] e;
    req_i.data_req      = 1'b1;
    req_i.address_index = 12'h010;
    #1;
    checks++; if (rsp_o.data_gnt !== 1'b1) begin errors++; $display("FAIL %s gnt: got %b want 1", nm, rsp_o.data_gnt); end
    next_cyc();
    req_i.data_req    = 1'b0;
    req_i.kill_req    = 1'b1;
    req_i.tag_valid   = with_tag;
    req_i.address_tag = 22'h08_0000;
    exp_q.push_back(64'h0);
    next_cyc();
    req_i.kill_req  = 1'b0;
    req_i.tag_valid = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++; if (rsp_o.data_rvalid !== 1'b1) begin errors++; $display("FAIL %s rvalid_c2: got %b want 1", nm, rsp_o.data_rvalid); end
    checks++; if (rsp_o.data_rdata !== e) begin errors++; $display("FAIL %s rdata: got %h want %h", nm, rsp_o.data_rdata, e); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err: got %b want 0", nm, err); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL %s mem_req: got %b want 0", nm, mem_req); end
    drive_idle();
    next_cyc();
  endtask

  task automatic test_write();
    int seen;
    req_i.data_req      = 1'b1;
    req_i.data_we       = 1'b1;
    req_i.address_index = 12'h020;
    #1;
    checks++; if (rsp_o.data_gnt !== 1'b1) begin errors++; $display("FAIL write gnt: got %b want 1", rsp_o.data_gnt); end
    next_cyc();
    req_i.data_req    = 1'b0;
    req_i.data_we     = 1'b0;
    req_i.tag_valid   = 1'b1;
    req_i.address_tag = 22'h08_0000;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL write err_c1: got %b want 1", err); end
    next_cyc();
    req_i.tag_valid = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL write err_c2: got %b want 0", err); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_o.data_rvalid === 1'b1 || mem_req === 1'b1) seen++;
      next_cyc();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL write no_rvalid: got %0d cycles with rvalid/mem_req want 0", seen); end
    drive_idle();
  endtask

  task automatic test_range_reject(input logic [PLEN-1:0] paddr, input string nm);
    logic [63:0] e;
    req_i.data_req      = 1'b1;
    req_i.address_index = paddr[IDX_W-1:0];
    #1;
    checks++; if (rsp_o.data_gnt !== 1'b1) begin errors++; $display("FAIL %s gnt: got %b want 1", nm, rsp_o.data_gnt); end
    next_cyc();
    req_i.data_req    = 1'b0;
    req_i.tag_valid   = 1'b1;
    req_i.address_tag = paddr[PLEN-1:IDX_W];
    exp_q.push_back(64'h0);
    next_cyc();
    req_i.tag_valid = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++; if (rsp_o.data_rvalid !== 1'b1) begin errors++; $display("FAIL %s rvalid_c2: got %b want 1", nm, rsp_o.data_rvalid); end
    checks++; if (rsp_o.data_rdata !== e) begin errors++; $display("FAIL %s rdata: got %h want %h", nm, rsp_o.data_rdata, e); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL %s err: got %b want 1", nm, err); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL %s mem_req: got %b want 0", nm, mem_req); end
    next_cyc();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err_width: got %b want 0", nm, err); end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    int seen;
    req_i.data_req      = 1'b1;
    req_i.address_index = 12'h040;
    #1;
    checks++; if (rsp_o.data_gnt !== 1'b1) begin errors++; $display("FAIL rstmid gnt: got %b want 1", rsp_o.data_gnt); end
    next_cyc();
    req_i.data_req    = 1'b0;
    req_i.tag_valid   = 1'b1;
    req_i.address_tag = 22'h08_0000;
    next_cyc();
    req_i.tag_valid = 1'b0;
    mem_gnt = 1'b1;
    next_cyc();
    mem_gnt = 1'b0;
    rst_ni  = 1'b0;
    #1;
    checks++; if (rsp_o !== '0 || mem_req !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rstmid outputs: got rsp=%h mem_req=%b err=%b want all 0", rsp_o, mem_req, err);
    end
    next_cyc();
    rst_ni = 1'b1;
    next_cyc();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1111_2222_3333_4444;
    next_cyc();
    mem_rvalid = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_o.data_rvalid === 1'b1) seen++;
      next_cyc();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid stale_rvalid: got %0d want 0", seen); end
    drive_idle();
  endtask

  initial begin
    test_reset();
    do_load(34'h0_8000_0010, 64'hDEAD_BEEF_0000_00CF, 0, 0, 1'b0, "load_basic");
    do_load(34'h0_8000_0010, 64'hDEAD_BEEF_0000_00CF, 3, 2, 1'b1, "load_slow");
    do_load(34'h0_8000_0014, 64'h0123_4567_89AB_CDEF, 1, 0, 1'b0, "load_unaligned");
    test_kill(1'b1, "kill_tag");
    do_load(34'h0_8000_0108, 64'hFEDC_BA98_7654_3210, 0, 1, 1'b0, "load_after_kill");
    test_kill(1'b0, "kill_notag");
`ifdef PTW_RESP_RANGE_CHK_EN
    test_range_reject(34'h0_7FFF_FFF8, "range_below");
    do_load(34'h0_8000_FFF8, 64'hCAFE_F00D_1234_5678, 0, 0, 1'b0, "range_last");
    test_range_reject(34'h0_8001_0000, "range_above");
`else
    do_load(34'h0_7FFF_FFF8, 64'hCAFE_F00D_1234_5678, 0, 0, 1'b0, "nochk_below");
    do_load(34'h0_8001_0000, 64'h0BAD_0BAD_0BAD_0BAD, 0, 0, 1'b0, "nochk_above");
`endif
    test_write();
    do_load(34'h0_8000_0200, 64'h7777_8888_9999_AAAA, 0, 0, 1'b0, "load_after_write");
    test_reset_mid();
    do_load(34'h0_8000_0300, 64'h1357_9BDF_2468_ACE0, 2, 1, 1'b0, "load_after_reset");
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
